// File: rtl/ula_pkg.sv
// Shared definitions for the ULA controller: opcode map, IR field layout and FSM states.
package ula_pkg;

  localparam int REG_W    = 8;
  localparam int IDX_W    = 2;
  localparam int NREG_DEF = 4;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDI = 4'b0001;
  localparam logic [3:0] OP_NOT = 4'b1000;
  localparam logic [3:0] OP_AND = 4'b1001;
  localparam logic [3:0] OP_OR  = 4'b1010;
  localparam logic [3:0] OP_XOR = 4'b1011;
  localparam logic [3:0] OP_ADD = 4'b1100;
  localparam logic [3:0] OP_SUB = 4'b1101;
  localparam logic [3:0] OP_SLR = 4'b1110;
  localparam logic [3:0] OP_SRR = 4'b1111;

  localparam int IR_OP_MSB = 7;
  localparam int IR_OP_LSB = 4;
  localparam int IR_RA_MSB = 3;
  localparam int IR_RA_LSB = 2;
  localparam int IR_RB_MSB = 1;
  localparam int IR_RB_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IMM,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_t;

  // Every opcode with the top bit set belongs to the ALU class.
  function automatic logic is_alu_op(input logic [3:0] op);
    return op[3];
  endfunction

  function automatic logic is_illegal_op(input logic [3:0] op);
    return !op[3] && (op[2:1] != 2'b00);
  endfunction

endpackage

// File: rtl/ula_regfile.sv
// 4x8 register file: two operand read ports, one debug read port, one synchronous write port.
module ula_regfile
  import ula_pkg::*;
#(
  parameter int NREG = NREG_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [REG_W-1:0] wdata,
  input  logic [IDX_W-1:0] ra_addr,
  input  logic [IDX_W-1:0] rb_addr,
  input  logic [IDX_W-1:0] dbg_addr,
  output logic [REG_W-1:0] ra_data,
  output logic [REG_W-1:0] rb_data,
  output logic [REG_W-1:0] dbg_data
);

  logic [REG_W-1:0] regs [NREG];

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          regs[gi] <= '0;
        end else if (we && (waddr == IDX_W'(gi))) begin
          regs[gi] <= wdata;
        end
      end
    end
  endgenerate

  // Reads are combinational, so a same-cycle write is seen only from the next cycle.
  assign ra_data  = regs[ra_addr];
  assign rb_data  = regs[rb_addr];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/ula_ctrl.sv
// Instruction sequencer for an external ULA. Define ULA_CTRL_ILLEGAL_TRAP_EN to trap
// illegal opcodes into HALT with a sticky err flag; otherwise they execute as NOP.
module ula_ctrl
  import ula_pkg::*;
#(
  parameter int NREG = NREG_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [7:0]       instr,
  output logic             instr_ready,
  output logic [3:0]       alu_op,
  output logic [REG_W-1:0] alu_a,
  output logic [REG_W-1:0] alu_b,
  input  logic [REG_W-1:0] alu_result,
  input  logic             alu_carry,
  output logic             busy,
  output logic             carry_flag,
  output logic             err,
  input  logic [IDX_W-1:0] dbg_sel,
  output logic [REG_W-1:0] dbg_data
);

  state_t           state_reg;
  logic [7:0]       ir_reg;
  logic             carry_flag_reg;
  logic             busy_reg;
  logic             ready_reg;
  logic             err_reg;

  logic [3:0]       ir_op;
  logic [IDX_W-1:0] ir_ra;
  logic [IDX_W-1:0] ir_rb;
  logic [3:0]       in_op;
  logic             transfer;
  logic             alu_active;
  logic             rf_we;
  logic [REG_W-1:0] rf_wdata;
  logic [REG_W-1:0] ra_data;
  logic [REG_W-1:0] rb_data;

  assign ir_op      = ir_reg[IR_OP_MSB:IR_OP_LSB];
  assign ir_ra      = ir_reg[IR_RA_MSB:IR_RA_LSB];
  assign ir_rb      = ir_reg[IR_RB_MSB:IR_RB_LSB];
  assign in_op      = instr[IR_OP_MSB:IR_OP_LSB];
  assign transfer   = instr_valid && ready_reg;
  assign alu_active = (state_reg == ST_EXEC) || (state_reg == ST_WB);

  assign rf_we    = ((state_reg == ST_IMM) && transfer) || (state_reg == ST_WB);
  assign rf_wdata = (state_reg == ST_WB) ? alu_result : instr;

  ula_regfile #(.NREG(NREG)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (ir_ra),
    .wdata    (rf_wdata),
    .ra_addr  (ir_ra),
    .rb_addr  (ir_rb),
    .dbg_addr (dbg_sel),
    .ra_data  (ra_data),
    .rb_data  (rb_data),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      ir_reg         <= '0;
      carry_flag_reg <= 1'b0;
      busy_reg       <= 1'b0;
      ready_reg      <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          ready_reg <= 1'b1;
          if (transfer) begin
            ir_reg <= instr;
            if (is_alu_op(in_op)) begin
              state_reg <= ST_EXEC;
              busy_reg  <= 1'b1;
              ready_reg <= 1'b0;
            end else if (in_op == OP_LDI) begin
              state_reg <= ST_IMM;
              busy_reg  <= 1'b1;
            end else if (is_illegal_op(in_op)) begin
`ifdef ULA_CTRL_ILLEGAL_TRAP_EN
              state_reg <= ST_HALT;
              busy_reg  <= 1'b1;
              ready_reg <= 1'b0;
              err_reg   <= 1'b1;
`endif
            end
          end
        end
        ST_IMM: begin
          if (transfer) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        ST_EXEC: begin
          state_reg <= ST_WB;
        end
        ST_WB: begin
          carry_flag_reg <= alu_carry;
          state_reg      <= ST_IDLE;
          busy_reg       <= 1'b0;
          ready_reg      <= 1'b1;
        end
        ST_HALT: begin
          busy_reg  <= 1'b1;
          ready_reg <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          ready_reg <= 1'b0;
        end
      endcase
    end
  end

  // Operand buses are quiet outside EXEC/WB so the ULA sees a NOP on 0,0.
  assign alu_op      = alu_active ? ir_op : OP_NOP;
  assign alu_a       = alu_active ? ra_data : '0;
  assign alu_b       = alu_active ? rb_data : '0;
  assign instr_ready = ready_reg;
  assign busy        = busy_reg;
  assign carry_flag  = carry_flag_reg;

`ifdef ULA_CTRL_ILLEGAL_TRAP_EN
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ula_ctrl.sv
// Bench for ula_ctrl with an attached behavioural ULA and an arithmetic reference model.
module tb_ula_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic [7:0] instr = 8'h00;
  logic       instr_ready;
  logic [3:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_result;
  logic       alu_carry;
  logic       busy, carry_flag, err;
  logic [1:0] dbg_sel = 2'd0;
  logic [7:0] dbg_data;

  int errors = 0;
  int checks = 0;

  int ref_regs [4];
  int ref_carry;

  always #5 clk = ~clk;

  ula_ctrl #(.NREG(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_carry(alu_carry), .busy(busy),
    .carry_flag(carry_flag), .err(err), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  // The ULA attached to the controller: shifts move by one, SUB carry is borrow.
  always_comb begin
    alu_result = 8'h00;
    alu_carry  = 1'b0;
    case (alu_op)
      4'h8: alu_result = ~alu_a;
      4'h9: alu_result = alu_a & alu_b;
      4'hA: alu_result = alu_a | alu_b;
      4'hB: alu_result = alu_a ^ alu_b;
      4'hC: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      4'hD: {alu_carry, alu_result} = {1'b0, alu_a} - {1'b0, alu_b};
      4'hE: {alu_carry, alu_result} = {alu_a, 1'b0};
      4'hF: {alu_result, alu_carry} = {1'b0, alu_a};
      default: ;
    endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the opcode semantics.
  task automatic model_apply(input logic [7:0] ins, input logic [7:0] imm);
    int op, ra, rb, a, b, r, c;
    op = int'(ins) / 16;
    ra = (int'(ins) / 4) % 4;
    rb = int'(ins) % 4;
    a = ref_regs[ra];
    b = ref_regs[rb];
    r = a;
    c = 0;
    if (op == 1) begin
      ref_regs[ra] = int'(imm);
      return;
    end
    if (op < 8) return;
    case (op)
      8:  r = 255 - a;
      9:  r = a & b;
      10: r = a | b;
      11: r = a ^ b;
      12: begin r = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
      13: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      14: begin r = (a * 2) % 256; c = (a >= 128) ? 1 : 0; end
      default: begin r = a / 2; c = a % 2; end
    endcase
    ref_regs[ra] = r;
    ref_carry = c;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) chk("send_ready_timeout", 0, 1);
    instr_valid = 1'b1;
    instr = b;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic exec(input logic [7:0] ins, input logic [7:0] imm);
    send(ins);
    if (ins[7:4] == 4'h1) send(imm);
    wait_idle();
    model_apply(ins, imm);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), int'(dbg_data), ref_regs[i]);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    instr_valid = 1'b0;
    for (int i = 0; i < 4; i++) ref_regs[i] = 0;
    ref_carry = 0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(instr_ready), 0);
    chk("rst_carry", int'(carry_flag), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_alu", int'({alu_op, alu_a, alu_b}), 0);
    check_regs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready_rise", int'(instr_ready), 1);
  endtask

  typedef struct {
    logic [7:0] ins;
    logic [7:0] imm;
    logic [1:0] reg_idx;
    logic [7:0] exp_val;
    logic       exp_carry;
  } vec_t;

  vec_t vecs [13];

  initial begin
    vecs[0]  = '{8'h14, 8'h0F, 2'd1, 8'h0F, 1'b0};
    vecs[1]  = '{8'h18, 8'h03, 2'd2, 8'h03, 1'b0};
    vecs[2]  = '{8'hC6, 8'h00, 2'd1, 8'h12, 1'b0};
    vecs[3]  = '{8'h14, 8'h81, 2'd1, 8'h81, 1'b0};
    vecs[4]  = '{8'h18, 8'h01, 2'd2, 8'h01, 1'b0};
    vecs[5]  = '{8'hE6, 8'h00, 2'd1, 8'h02, 1'b1};
    vecs[6]  = '{8'hF6, 8'h00, 2'd1, 8'h01, 1'b0};
    vecs[7]  = '{8'h84, 8'h00, 2'd1, 8'hFE, 1'b0};
    vecs[8]  = '{8'hD6, 8'h00, 2'd1, 8'hFD, 1'b0};
    vecs[9]  = '{8'h10, 8'h10, 2'd0, 8'h10, 1'b0};
    vecs[10] = '{8'hD1, 8'h00, 2'd0, 8'h13, 1'b1};
    vecs[11] = '{8'hC5, 8'h00, 2'd1, 8'hFA, 1'b1};
    vecs[12] = '{8'h00, 8'h00, 2'd1, 8'hFA, 1'b1};

    apply_reset();

    for (int i = 0; i < 13; i++) begin
      exec(vecs[i].ins, vecs[i].imm);
      dbg_sel = vecs[i].reg_idx;
      #1;
      chk($sformatf("vec%0d_reg", i), int'(dbg_data), int'(vecs[i].exp_val));
      chk($sformatf("vec%0d_carry", i), int'(carry_flag), int'(vecs[i].exp_carry));
      $display("vec %0d instr=%02h imm=%02h r%0d=%02h carry=%0d", i, vecs[i].ins,
               vecs[i].imm, vecs[i].reg_idx, dbg_data, carry_flag);
    end

    // ADD timing: operands visible in EXEC, ready low for exactly EXEC and WB.
    exec(8'h14, 8'h0F);
    exec(8'h18, 8'h03);
    chk("idle_alu_quiet", int'({alu_op, alu_a, alu_b}), 0);
    send(8'hC6);
    @(negedge clk);
    chk("exec_op", int'(alu_op), 12);
    chk("exec_a", int'(alu_a), 8'h0F);
    chk("exec_b", int'(alu_b), 8'h03);
    chk("exec_ready", int'(instr_ready), 0);
    chk("exec_busy", int'(busy), 1);
    @(negedge clk);
    chk("wb_ready", int'(instr_ready), 0);
    chk("wb_a_held", int'(alu_a), 8'h0F);
    @(negedge clk);
    chk("post_wb_ready", int'(instr_ready), 1);
    chk("post_wb_busy", int'(busy), 0);
    dbg_sel = 2'd1;
    #1;
    chk("add_r1", int'(dbg_data), 8'h12);
    model_apply(8'hC6, 8'h00);
    $display("seq add_timing r1=%02h", dbg_data);

    // LDI with the immediate withheld for 5 cycles.
    send(8'h14);
    dbg_sel = 2'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("imm_hold_busy", int'(busy), 1);
      chk("imm_hold_ready", int'(instr_ready), 1);
      chk("imm_hold_r1", int'(dbg_data), 8'h12);
    end
    instr_valid = 1'b1;
    instr = 8'hA5;
    #1;
    chk("imm_same_cycle_old", int'(dbg_data), 8'h12);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    chk("imm_written", int'(dbg_data), 8'hA5);
    model_apply(8'h14, 8'hA5);
    wait_idle();
    $display("seq ldi_hold r1=%02h", dbg_data);

    // Reset during WB aborts the write-back.
    exec(8'h14, 8'hFF);
    exec(8'h18, 8'h01);
    send(8'hC6);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) ref_regs[i] = 0;
    ref_carry = 0;
    #1;
    chk("wb_rst_carry", int'(carry_flag), 0);
    check_regs("wb_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("wb_rst_ready", int'(instr_ready), 1);
    $display("seq reset_in_wb done");

    // Randomised legal instructions against the reference model.
    for (int t = 0; t < 150; t++) begin
      logic [7:0] ins, imm;
      ins = 8'($urandom);
      imm = 8'($urandom);
      if (ins[7:4] >= 4'h2 && ins[7:4] <= 4'h7) ins[7] = 1'b1;
      exec(ins, imm);
      dbg_sel = ins[3:2];
      #1;
      chk("rand_reg", int'(dbg_data), ref_regs[ins[3:2]]);
      chk("rand_carry", int'(carry_flag), ref_carry);
      $display("rand %0d instr=%02h imm=%02h r%0d=%02h carry=%0d", t, ins, imm,
               ins[3:2], dbg_data, carry_flag);
    end
    check_regs("rand_end");

    // Illegal opcode.
    send(8'h55);
`ifdef ULA_CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("trap_err", int'(err), 1);
      chk("trap_busy", int'(busy), 1);
      chk("trap_ready", int'(instr_ready), 0);
    end
    apply_reset();
`else
    @(negedge clk);
    chk("illegal_err", int'(err), 0);
    chk("illegal_busy", int'(busy), 0);
    chk("illegal_ready", int'(instr_ready), 1);
    chk("illegal_carry", int'(carry_flag), ref_carry);
    check_regs("illegal");
`endif
    $display("seq illegal err=%0d busy=%0d", err, busy);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/ula_ctrl.md
ULA_CTRL -- requirements
Module: ula_ctrl

Interface
REQ-001 Parameter NREG, default 4, number of 8-bit general registers; fixed at 4 and indexed by 2-bit fields.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 instr_valid  input  1  instruction or immediate byte present on instr.
REQ-005 instr  input  8  [7:4] opcode, [3:2] ra index (source A and destination), [1:0] rb index (source B).
REQ-006 instr_ready  output  1  block accepts instr this cycle; a beat transfers when instr_valid and instr_ready are both 1.
REQ-007 alu_op  output  4  opcode driven to the ULA.
REQ-008 alu_a  output  8  operand A, the value of register ra.
REQ-009 alu_b  output  8  operand B, the value of register rb.
REQ-010 alu_result  input  8  ULA result, combinational from alu_a, alu_b and alu_op.
REQ-011 alu_carry  input  1  ULA carry_out.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 carry_flag  output  1  carry latched at the last ALU write-back.
REQ-014 err  output  1  sticky illegal-opcode flag (see Configuration).
REQ-015 dbg_sel  input  2  register index for the debug read port.
REQ-016 dbg_data  output  8  combinational value of register dbg_sel.

Function
REQ-017 Opcode map:
- 0000 NOP.
- 0001 LDI: the next accepted beat is written to register ra.
- 0010–0111 illegal.
- 1000 NOT, 1001 AND, 1010 OR, 1011 XOR, 1100 ADD, 1101 SUB, 1110 SLR, 1111 SRR: ALU class.
REQ-018 FSM states: IDLE, IMM, EXEC, WB, HALT.
REQ-019 IDLE: instr_ready=1; on a transfer the beat is latched into the instruction register (IR).
- ALU class goes to EXEC.
- LDI goes to IMM.
- NOP stays in IDLE.
- Illegal opcode is handled per REQ-030/031.
REQ-020 IMM: instr_ready=1; on a transfer, register IR.ra is written with instr and the state returns to IDLE; without a transfer the state holds.
REQ-021 EXEC: alu_op=IR[7:4], alu_a=reg[IR.ra], alu_b=reg[IR.rb]; one cycle, then WB.
REQ-022 WB: alu outputs are held as in EXEC; reg[IR.ra] is written with alu_result and carry_flag with alu_carry; then IDLE.
REQ-023 ALU instruction latency is 3 cycles from transfer to IDLE; the write is visible on dbg_data in the cycle after WB.
REQ-024 instr_ready=0 in EXEC, WB and HALT.
REQ-025 Outside EXEC/WB, alu_op=0000 and alu_a=alu_b=0.
REQ-026 ra==rb is legal: both operands read the same register, and the result overwrites it.
REQ-027 A register write and a dbg_data read of the same index in the same cycle return the old value.
REQ-028 NOP and LDI leave carry_flag unchanged.

Reset
REQ-029 While rst_n=0:
- state is IDLE, IR=0, all registers 0x00;
- carry_flag=0, err=0, busy=0, instr_ready=0;
- alu_op=0000, alu_a=alu_b=0.
- instr_ready rises in the first cycle after release.
- Reset asserted in IMM, EXEC or WB aborts the instruction with no register or flag write.

Configuration
REQ-030 With macro ULA_CTRL_ILLEGAL_TRAP_EN defined, an illegal opcode sets err=1 and moves the FSM to HALT; the FSM leaves HALT only on reset.
REQ-031 Without ULA_CTRL_ILLEGAL_TRAP_EN, an illegal opcode executes as NOP and err is tied to 0.

Structure
REQ-032 Package ula_pkg holds the opcode constants (NOP, LDI, NOT…SRR), the FSM state typedef and the IR field positions.
REQ-033 Sub-module ula_regfile holds the 4x8 registers, with two read ports plus the debug read port and one synchronous write port with asynchronous clear.
REQ-034 The ULA itself is instantiated outside ula_ctrl.

Verification
REQ-035 Scenarios, each with the ULA attached:
- Reset release, then instr=0x14 followed by 0x0F, then 0x18 followed by 0x03 -> r1=0x0F, r2=0x03; carry_flag=0.
- Continuing from the previous state, instr=0xC6 (ADD r1,r2) -> alu_a=0x0F and alu_b=0x03 in EXEC; r1=0x12 after WB; instr_ready low for exactly 2 cycles.
- Load r1=0x81, r2=0x01, then 0xE6 (SLR) -> r1=0x02, carry_flag=1; then 0xF6 (SRR) -> r1=0x01, carry_flag=0.
- instr=0x55 with ULA_CTRL_ILLEGAL_TRAP_EN defined -> err=1, busy=1 and instr_ready=0 until reset; without the macro -> no state change and err=0.
- rst_n pulsed low during WB of 0xC6 -> r1 and carry_flag are not updated, and all registers read 0x00.
- LDI 0x14 with instr_valid held low for 5 cycles in IMM -> state holds IMM and busy=1; r1 is written only on the eventual transfer.
